// File: rtl/io_pkg.sv
// Shared types and widths for the IO port controller slice.
package io_pkg;

  localparam int DATA_W = 32;
  localparam int SW_W   = 18;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    WAIT_PRESS   = 2'd1,
    WAIT_RELEASE = 2'd2,
    DONE         = 2'd3
  } state_t;

endpackage

// File: rtl/button_debounce.sv
// Confirm-button synchronizer and debouncer; reports the accepted pressed level.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic pressed
);

  logic             btn_s1;
  logic             btn_s2;
  logic [CNT_W-1:0] cnt;
  logic             raw_pressed;

  assign raw_pressed = ~btn_s2;

  // Two-flop synchronizer; idles at the released (high) level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_s1 <= 1'b1;
      btn_s2 <= 1'b1;
    end else begin
      btn_s1 <= btn_n;
      btn_s2 <= btn_s1;
    end
  end

  // Count consecutive disagreeing cycles; accept the new level after DEBOUNCE_CYCLES of them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      pressed <= 1'b0;
    end else if (raw_pressed == pressed) begin
      cnt <= '0;
    end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      pressed <= raw_pressed;
      cnt     <= '0;
    end else if (cnt != '1) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/io_port_controller.sv
// Stalls the decoder on in/out instructions until the user confirms with one button press.
module io_port_controller
  import io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_req,
  input  logic              out_req,
  input  logic [DATA_W-1:0] out_data,
  input  logic [SW_W-1:0]   sw,
  input  logic              btn_n,
  output logic              flag,
  output logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_valid
);

  state_t          state;
  logic [SW_W-1:0] sw_s1;
  logic [SW_W-1:0] sw_s2;
  logic            pressed;
  logic            pressed_q;
  logic            press_evt;
  logic            release_evt;
  logic            op_in;
  logic            req;

  button_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_debounce (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_n   (btn_n),
    .pressed (pressed)
  );

  assign req         = in_req | out_req;
  assign flag        = req & (state != DONE);
  assign press_evt   = pressed & ~pressed_q;
  assign release_evt = ~pressed & pressed_q;

  // Two-flop synchronizer for the switch bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_s1 <= '0;
      sw_s2 <= '0;
    end else begin
      sw_s1 <= sw;
      sw_s2 <= sw_s1;
    end
  end

  // Handshake FSM with registered capture/display outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      in_data    <= '0;
      disp_data  <= '0;
      disp_valid <= 1'b0;
      op_in      <= 1'b0;
      pressed_q  <= 1'b0;
    end else begin
      pressed_q <= pressed;
      case (state)
        IDLE: begin
          if (in_req) begin
            op_in <= 1'b1;
            state <= WAIT_PRESS;
          end else if (out_req) begin
            op_in      <= 1'b0;
            disp_data  <= out_data;
            disp_valid <= 1'b0;
            state      <= WAIT_PRESS;
          end
        end
        WAIT_PRESS: begin
          if (!req) begin
            state <= IDLE;
          end else if (press_evt) begin
            if (op_in) begin
              in_data <= {{(DATA_W - SW_W){1'b0}}, sw_s2};
            end
            state <= WAIT_RELEASE;
          end
        end
        WAIT_RELEASE: begin
          if (!req) begin
            state <= IDLE;
          end else if (release_evt) begin
            state <= DONE;
          end
        end
        DONE: begin
          if (!op_in) begin
            disp_valid <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
